// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the M stage of the pipelined
// datapath. One load or store is accepted at a time. It completes after
// WAIT_CYCLES wait states, and the DONE cycle carries a one-cycle MemDoneM
// pulse. MemStallM holds the pipeline while an access is outstanding.
//
// State table
//   IDLE | waiting for MemReqM; an accept latches the request fields
//   BUSY | wait states; the counter runs down from WAIT_CYCLES to 1
//   DONE | completion cycle; MemDoneM high, back to IDLE on next edge
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  wait states between accept and completion (0..15)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   MemReqM     request valid, held until MemDoneM
//   MemWriteM   1 = store, 0 = load (sampled at accept)
//   ALUResultM  byte address (sampled at accept)
//   WriteDataM  store data (sampled at accept)
//   ReadDataM   registered load result
//   MemDoneM    one-cycle completion pulse
//   MemErrM     out-of-range flag, qualified by MemDoneM
//   MemStallM   freeze request to the hazard unit

module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemDoneM,
  output logic        MemErrM,
  output logic        MemStallM
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [3:0]    cnt, cnt_next;
  logic          accept;
  logic          complete;
  logic          mem_we;

  // Fields latched at accept
  logic          write_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;

  // Effective transaction fields at the completing edge
  logic          cur_write;
  logic          cur_err;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;

  logic          addr_oor;
  logic [31:0]   mem [DEPTH];

  // Byte offset is ignored; accesses are word-only.
  logic          unused_addr_lsb;
  assign unused_addr_lsb = ^ALUResultM[1:0];

  assign addr_oor = |ALUResultM[31:AW+2];

  // With zero wait states the accept edge is also the completing edge. The
  // latches are not loaded yet at that edge, so the live inputs are used.
  always_comb begin
    if (accept) begin
      cur_write = MemWriteM;
      cur_err   = addr_oor;
      cur_idx   = ALUResultM[AW+1:2];
      cur_wdata = WriteDataM;
    end else begin
      cur_write = write_q;
      cur_err   = err_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (MemReqM) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = DONE;
            complete   = 1'b1;
            cnt_next   = 4'd0;
          end else begin
            state_next = BUSY;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = DONE;
          complete   = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A store commits only on a clean completing edge. It is also masked
  // while reset is held, so that a held request cannot write when there are
  // zero wait states.
  always_comb begin
    mem_we = complete & cur_write & ~cur_err & ~reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      write_q <= MemWriteM;
      err_q   <= addr_oor;
      idx_q   <= ALUResultM[AW+1:2];
      wdata_q <= WriteDataM;
    end
  end

  // A store leaves ReadDataM untouched. An out-of-range access clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadDataM <= 32'd0;
    end else if (complete) begin
      if (cur_err) begin
        ReadDataM <= 32'd0;
      end else if (!cur_write) begin
        ReadDataM <= mem[cur_idx];
      end
    end
  end

  // The array has no reset, so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  // err_q keeps the range error of the transaction in flight through DONE.
  assign MemDoneM  = (state == DONE);
  assign MemErrM   = MemDoneM & err_q;
  assign MemStallM = MemReqM & ~MemDoneM;

endmodule
